iop_dmem_responder: RTL

//  Memory-side responder for the IOP408 data port. Accepts IOP byte reads/writes
//  (21-bit address, 8-bit data), drives IOPRWAIT/IOPWWAIT back to the core, and

---
 rtl/iop_dmem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/iop_dmem_responder.sv
// iop_dmem_responder: IOP408 data-port responder with a one-entry posted write buffer and bus timeout
module iop_dmem_responder #(
  parameter int AW      = 21,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          sysclk,
  input  logic          sysrst,
  input  logic          iop_read,
  input  logic          iop_write,
  input  logic [AW-1:0] IOPRADDR,
  input  logic [AW-1:0] IOPWADDR,
  input  logic [DW-1:0] IOPWDATA,
  output logic [DW-1:0] IOPRDATA,
  output logic          IOPRWAIT,
  output logic          IOPWWAIT,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  // the TIMEOUT-th consecutive unacked cycle is the last one bus_req is held
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WR_BUS, RD_BUS, RD_DONE} state_t;
  state_t        state, state_nx;
  logic          wbuf_full, wr_acc, on_bus, expired, bus_end;
  logic [AW-1:0] wbuf_addr, rd_addr;
  logic [DW-1:0] wbuf_data;
  logic [TW-1:0] timer;
  assign wr_acc    = iop_write & ~wbuf_full;
  assign on_bus    = (state == WR_BUS) || (state == RD_BUS);
  assign expired   = on_bus & ~bus_ack & (timer == T_LAST);
  assign bus_end   = on_bus & (bus_ack | expired);
  // stalls are forced low while reset is asserted so the core sees a quiet port
  assign IOPWWAIT  = sysrst & iop_write & wbuf_full;
  assign IOPRWAIT  = sysrst & iop_read & (state != RD_DONE);
  assign bus_req   = on_bus;
  assign bus_we    = state == WR_BUS;
  assign bus_addr  = (state == WR_BUS) ? wbuf_addr : (state == RD_BUS) ? rd_addr : '0;
  assign bus_wdata = (state == WR_BUS) ? wbuf_data : '0;
  // next state: a write being accepted or already buffered beats a read (RAW ordering)
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)    ? ((wbuf_full | wr_acc) ? WR_BUS : iop_read ? RD_BUS : IDLE) :
               (state == RD_DONE) ? IDLE :
               bus_end            ? ((state == RD_BUS) ? RD_DONE : IDLE) : state;
  end
  // state register
  always_ff @(posedge sysclk or negedge sysrst)
    if (!sysrst) state <= IDLE;
    else state <= state_nx;
  // posted write buffer: fill on accept, free when its bus write acks or is abandoned
  always_ff @(posedge sysclk or negedge sysrst)
    if (!sysrst) begin
      wbuf_full <= 1'b0;
      wbuf_addr <= '0;
      wbuf_data <= '0;
    end else if (wr_acc) begin
      wbuf_full <= 1'b1;
      wbuf_addr <= IOPWADDR;
      wbuf_data <= IOPWDATA;
    end else if (state == WR_BUS && bus_end) begin
      wbuf_full <= 1'b0;
    end
  // read address latch, read data return, bus timer and sticky timeout flag
  always_ff @(posedge sysclk or negedge sysrst)
    if (!sysrst) begin
      rd_addr  <= '0;
      IOPRDATA <= '0;
      timer    <= '0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && state_nx == RD_BUS) rd_addr <= IOPRADDR;
      timer <= (on_bus && state_nx == state) ? timer + 1'b1 : '0;
      if (state == RD_BUS && bus_ack) IOPRDATA <= bus_rdata;
      else if (state == RD_BUS && expired) IOPRDATA <= '1;
      if (expired) err <= 1'b1;
    end
endmodule
